// File: rtl/vec_pkg.sv
// Shared definitions for the vector datapath scalar register bank:
// default sizes and the clear sequencer state encoding.
package vec_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_NUM_REGS = 8;
    localparam int DEF_NUM_DBG  = 4;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } clr_state_t;

endpackage

// File: rtl/banco_clr_fsm.sv
// Clear sequencer: walks every bank entry once, one per cycle,
// driving a zero-write into the bank's write mux.
module banco_clr_fsm
    import vec_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

    clr_state_t        state, state_nx;
    logic [ADDR_W-1:0] idx, idx_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        clr_we   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (clr_req) begin
                    state_nx = ST_CLEAR;
                    idx_nx   = '0;
                end
            end
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (idx == LAST) begin
                    state_nx = ST_IDLE;
                    idx_nx   = '0;
                end else begin
                    idx_nx = idx + ADDR_W'(1);
                end
            end
        endcase
    end

    assign clr_busy = (state == ST_CLEAR);
    assign clr_addr = idx;

endmodule

// File: rtl/banco_registros_sca.sv
// Scalar register bank: two registered read ports, one write port
// with same-cycle bypass, debug view and a sequenced bank clear.
module banco_registros_sca
    import vec_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_DBG  = DEF_NUM_DBG
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      reg_rd,
    input  logic [ADDR_W-1:0]         reg_sca1,
    input  logic [ADDR_W-1:0]         reg_sca2,
    output logic [DATA_W-1:0]         sca1,
    output logic [DATA_W-1:0]         sca2,
    input  logic                      reg_wr,
    input  logic [ADDR_W-1:0]         dir_wrs,
    input  logic [DATA_W-1:0]         data_wr,
    input  logic                      clr_req,
    output logic                      clr_busy,
    output logic [NUM_DBG*DATA_W-1:0] dbg_regs
);

    localparam logic [ADDR_W:0] NREG = (ADDR_W + 1)'(NUM_REGS);

    logic [DATA_W-1:0] mem [NUM_REGS];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_ok;
    logic [DATA_W-1:0] rd1, rd2;

    banco_clr_fsm #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_clr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign wr_ok = reg_wr && !clr_busy && ({1'b0, dir_wrs} < NREG);

    // Clear and user writes never coincide: wr_ok is gated by clr_busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                unique case (1'b1)
                    (clr_we && clr_addr == ADDR_W'(i)): mem[i] <= '0;
                    (wr_ok && dir_wrs == ADDR_W'(i)):   mem[i] <= data_wr;
                    default: ;
                endcase
            end
        end
    end

    // Out-of-range addresses match no entry and read as zero.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_sca1 == ADDR_W'(i)) rd1 = mem[i];
            if (reg_sca2 == ADDR_W'(i)) rd2 = mem[i];
        end
        if (reg_wr && dir_wrs == reg_sca1) rd1 = data_wr;
        if (reg_wr && dir_wrs == reg_sca2) rd2 = data_wr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sca1 <= '0;
            sca2 <= '0;
        end else if (reg_rd) begin
            sca1 <= clr_busy ? '0 : rd1;
            sca2 <= clr_busy ? '0 : rd2;
        end
    end

    for (genvar g = 0; g < NUM_DBG; g++) begin : g_dbg
        assign dbg_regs[g*DATA_W +: DATA_W] = mem[g];
    end

endmodule

// File: tb/tb_banco_registros_sca.sv
// Bench for banco_registros_sca: an 8x8 and a 6x16 instance share one
// stimulus stream and are compared every cycle against a bank model.
module tb_banco_registros_sca;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reg_rd = 1'b0;
    logic [2:0]  reg_sca1 = '0;
    logic [2:0]  reg_sca2 = '0;
    logic        reg_wr = 1'b0;
    logic [2:0]  dir_wrs = '0;
    logic [15:0] data_wr = '0;
    logic        clr_req = 1'b0;
    logic [7:0]  data8;

    logic [7:0]  u0_sca1, u0_sca2;
    logic        u0_busy;
    logic [31:0] u0_dbg;
    logic [15:0] u1_sca1, u1_sca2;
    logic        u1_busy;
    logic [63:0] u1_dbg;

    assign data8 = data_wr[7:0];

    always #5 clk = ~clk;

    banco_registros_sca u0 (
        .clk(clk), .rst_n(rst_n), .reg_rd(reg_rd),
        .reg_sca1(reg_sca1), .reg_sca2(reg_sca2),
        .sca1(u0_sca1), .sca2(u0_sca2),
        .reg_wr(reg_wr), .dir_wrs(dir_wrs), .data_wr(data8),
        .clr_req(clr_req), .clr_busy(u0_busy), .dbg_regs(u0_dbg)
    );

    banco_registros_sca #(.DATA_W(16), .NUM_REGS(6)) u1 (
        .clk(clk), .rst_n(rst_n), .reg_rd(reg_rd),
        .reg_sca1(reg_sca1), .reg_sca2(reg_sca2),
        .sca1(u1_sca1), .sca2(u1_sca2),
        .reg_wr(reg_wr), .dir_wrs(dir_wrs), .data_wr(data_wr),
        .clr_req(clr_req), .clr_busy(u1_busy), .dbg_regs(u1_dbg)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Bank model: index 0 is the 8x8 bank, index 1 the 6x16 bank.
    logic [15:0] mm [2][8];
    logic [15:0] e1 [2];
    logic [15:0] e2 [2];
    int          cnt [2];
    int          idx [2];

    function automatic int nregs(input int k);
        return (k == 0) ? 8 : 6;
    endfunction

    function automatic logic [15:0] msk(input int k);
        return (k == 0) ? 16'h00FF : 16'hFFFF;
    endfunction

    function automatic logic [15:0] rd_model(input int k, input int a);
        if (reg_wr && int'(dir_wrs) == a) return data_wr & msk(k);
        if (a >= nregs(k)) return 16'h0;
        return mm[k][a];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) mm[k][i] = '0;
            e1[k] = '0;
            e2[k] = '0;
            cnt[k] = 0;
            idx[k] = 0;
        end
    endtask

    initial model_reset();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (reg_rd) begin
                    e1[k] = (cnt[k] > 0) ? 16'h0 : rd_model(k, int'(reg_sca1));
                    e2[k] = (cnt[k] > 0) ? 16'h0 : rd_model(k, int'(reg_sca2));
                end
                if (cnt[k] > 0) begin
                    mm[k][idx[k]] = '0;
                    idx[k]++;
                    cnt[k]--;
                end else begin
                    if (reg_wr && int'(dir_wrs) < nregs(k))
                        mm[k][dir_wrs] = data_wr & msk(k);
                    if (clr_req) begin
                        cnt[k] = nregs(k);
                        idx[k] = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("u0_sca1", 32'(u0_sca1), 32'(e1[0][7:0]));
            chk("u0_sca2", 32'(u0_sca2), 32'(e2[0][7:0]));
            chk("u0_busy", 32'(u0_busy), 32'(cnt[0] > 0));
            chk("u1_sca1", 32'(u1_sca1), 32'(e1[1]));
            chk("u1_sca2", 32'(u1_sca2), 32'(e2[1]));
            chk("u1_busy", 32'(u1_busy), 32'(cnt[1] > 0));
            for (int i = 0; i < 4; i++) begin
                chk("u0_dbg", 32'(u0_dbg[i*8 +: 8]), 32'(mm[0][i][7:0]));
                chk("u1_dbg", 32'(u1_dbg[i*16 +: 16]), 32'(mm[1][i]));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        reg_rd = 1'b0;
        reg_wr = 1'b0;
        clr_req = 1'b0;
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        idle_in();
        reg_wr = 1'b1;
        dir_wrs = 3'(a);
        data_wr = d;
        cyc();
        reg_wr = 1'b0;
    endtask

    task automatic rd(input int a1, input int a2);
        idle_in();
        reg_rd = 1'b1;
        reg_sca1 = 3'(a1);
        reg_sca2 = 3'(a2);
        cyc();
        reg_rd = 1'b0;
    endtask

    int nb;

    initial begin
        repeat (3) cyc();
        rst_n = 1'b1;
        chk_en = 1'b1;
        chk("rst_u0_dbg", u0_dbg, 32'h0);
        chk("rst_u0_busy", 32'(u0_busy), 32'h0);

        for (int a = 0; a < 8; a++) begin
            rd(a, 7 - a);
            chk("rst_rd1", 32'(u0_sca1), 32'h0);
            chk("rst_rd2", 32'(u0_sca2), 32'h0);
        end

        wr(3, 16'hA55A);
        rd(3, 2);
        chk("wr3_sca1", 32'(u0_sca1), 32'h5A);
        chk("wr3_sca2", 32'(u0_sca2), 32'h00);
        chk("wr3_dbg3", 32'(u0_dbg[31:24]), 32'h5A);
        chk("wr3_u1", 32'(u1_sca1), 32'hA55A);

        reg_wr = 1'b1; dir_wrs = 3'd5; data_wr = 16'h12C3;
        reg_rd = 1'b1; reg_sca1 = 3'd5; reg_sca2 = 3'd5;
        cyc();
        chk("byp_sca1", 32'(u0_sca1), 32'hC3);
        chk("byp_sca2", 32'(u0_sca2), 32'hC3);
        chk("byp_u1", 32'(u1_sca2), 32'h12C3);

        idle_in();
        reg_sca1 = 3'd0;
        cyc();
        chk("hold_sca1", 32'(u0_sca1), 32'hC3);

        wr(7, 16'h0707);
        wr(6, 16'h0606);
        rd(7, 6);
        chk("oor_u0", 32'(u0_sca1), 32'h07);
        chk("oor_u1_7", 32'(u1_sca1), 32'h0);
        chk("oor_u1_6", 32'(u1_sca2), 32'h0);

        for (int i = 0; i < 8; i++) wr(i, {8'(i + 1), 8'((i + 1) * 8'h11)});
        rd(7, 0);
        chk("fill_r7", 32'(u0_sca1), 32'h88);
        chk("fill_r0", 32'(u0_sca2), 32'h11);

        idle_in();
        clr_req = 1'b1;
        cyc();
        nb = u0_busy ? 1 : 0;
        clr_req = 1'b0;
        reg_wr = 1'b1; dir_wrs = 3'd1; data_wr = 16'hFFFF;
        reg_rd = 1'b1; reg_sca1 = 3'd1; reg_sca2 = 3'd2;
        repeat (7) begin
            cyc();
            if (u0_busy) nb++;
            chk("clr_rd", 32'(u0_sca1), 32'h0);
        end
        cyc();
        chk("clr_end", 32'(u0_busy), 32'h0);
        chk("clr_len", 32'(nb), 32'd8);
        idle_in();
        for (int a = 0; a < 8; a++) begin
            rd(a, a);
            chk("post_clr", 32'(u0_sca1), 32'h0);
        end

        wr(4, 16'h0044);
        rd(4, 4);
        chk("pre_abort", 32'(u0_sca1), 32'h44);
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(u0_busy), 32'h0);
        chk("abort_sca1", 32'(u0_sca1), 32'h0);
        chk("abort_dbg", u0_dbg, 32'h0);
        chk("abort_u1", 32'(u1_sca1), 32'h0);
        cyc();
        rst_n = 1'b1;
        wr(0, 16'h0077);
        rd(0, 0);
        chk("post_rst_sca1", 32'(u0_sca1), 32'h77);
        chk("post_rst_dbg0", 32'(u0_dbg[7:0]), 32'h77);

        cyc();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/banco_registros_sca.md
# banco_registros_sca

Parametrised scalar register bank for the vector processor datapath, successor to the 8x8 single-read scalar bank. It provides two registered read ports, one write port on the rising edge with same-cycle write-to-read bypass, and a debug view of the low registers. A hardware clear sequencer zeroes the bank one entry per cycle, so the pipeline can flush scalar state without reset. It sits between decode (read addresses) and write-back (write port).

## Interface
- DATA_W, 8, scalar data width
- NUM_REGS, 8, number of registers (2..256, need not be a power of 2)
- ADDR_W, $clog2(NUM_REGS), address width
- NUM_DBG, 4, number of low registers exported on dbg_regs (1..NUM_REGS)

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- reg_rd  in  1  read enable for both read ports
- reg_sca1  in  ADDR_W  read address, port 1
- reg_sca2  in  ADDR_W  read address, port 2
- sca1  out  DATA_W  registered read data, port 1
- sca2  out  DATA_W  registered read data, port 2
- reg_wr  in  1  write enable
- dir_wrs  in  ADDR_W  write address
- data_wr  in  DATA_W  write data
- clr_req  in  1  start bank clear (single-cycle pulse or level)
- clr_busy  out  1  clear sequence in progress
- dbg_regs  out  NUM_DBG*DATA_W  mem[0] in bits [DATA_W-1:0], mem[i] at slice i; combinational view of storage

## Operation
- Reset (async, rst_n=0): all mem entries 0, sca1=sca2=0, clr_busy=0, state IDLE, clear index 0. dbg_regs therefore reads 0.
- Write: in IDLE, with reg_wr=1 and dir_wrs<NUM_REGS, mem[dir_wrs] is set to data_wr at the rising edge. Writes with dir_wrs>=NUM_REGS are dropped.
- Read: in IDLE, with reg_rd=1, at the rising edge scaN is loaded with:
  - data_wr if reg_wr=1 and dir_wrs==reg_scaN (bypass; both ports independently);
  - else 0 if reg_scaN>=NUM_REGS;
  - else mem[reg_scaN].
- With reg_rd=0, sca1 and sca2 hold their values.
- FSM states:
  - IDLE: clr_req=1 moves to CLEAR, sets index 0 and clr_busy=1.
  - CLEAR: each edge writes mem[index]=0 and increments index. At index==NUM_REGS-1 it writes the last entry, returns to IDLE and sets clr_busy=0.
- During CLEAR:
  - reg_wr is ignored (write dropped, no bypass).
  - reg_rd loads 0 into sca1/sca2.
  - clr_req is ignored.
- clr_req and reg_wr in the same IDLE cycle: the write is performed, then the clear begins and wipes it.
- rst_n asserted mid-CLEAR aborts the sequence to the reset state immediately.

## Timing
- Read latency 1 cycle: address sampled at edge k, data valid after edge k.
- A write at edge k is visible through storage to reads sampled at edge k+1 or later. A read sampled at edge k gets the write via bypass.
- Clear: clr_req sampled at edge k. clr_busy is high after edge k through edge k+NUM_REGS (NUM_REGS cycles). mem[i] becomes 0 at edge k+1+i. The first accepted write is at edge k+NUM_REGS+1.
- dbg_regs changes in the same cycle as storage (no extra register).

## Structure
- Shared package vec_pkg holds:
  - default DATA_W and NUM_REGS constants;
  - the clear FSM state enum (ST_IDLE, ST_CLEAR).
- One sub-module: banco_clr_fsm, containing the state register, clear index counter and clr_busy. It outputs clr_we and clr_addr to the bank's write mux.
- Storage is a flip-flop array (needed for async reset and dbg_regs), not inferred RAM.

## Test plan
- Reset then read all registers on both ports: sca1=sca2=0, dbg_regs=0.
- Write 0x5A to reg 3, then read reg 3 on port 1 and reg 2 on port 2 next cycle: sca1=0x5A, sca2=0x00, dbg_regs slice 3=0x5A.
- Bypass: same cycle reg_wr=1, dir_wrs=5, data_wr=0xC3, reg_rd=1, reg_sca1=reg_sca2=5: both ports read 0xC3 after the edge.
- Fill all 8 registers with 0x11..0x88, pulse clr_req:
  - clr_busy high for exactly 8 cycles;
  - a write of 0xFF to reg 1 during busy is dropped;
  - reads during busy return 0;
  - afterwards all registers read 0.
- NUM_REGS=6 instance: write to address 7 is dropped and a read of address 7 returns 0. Regression with DATA_W=16 on the write/read/bypass scenarios.
- Assert rst_n at cycle 3 of a clear: clr_busy=0 and all outputs 0 immediately. After release, a normal write/read of 0x77 to reg 0 works.
